// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with valid/ready handshakes on both sides.
// One word is loaded from IDLE, then shifted out one bit per downstream transfer.
module piso_serializer #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] din,
   output logic             in_ready,
   output logic             s_valid,
   output logic             s_data,
   output logic             s_last,
   input  logic             s_ready,
   output logic [7:0]       word_cnt
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [CW-1:0]    r_bit_cnt;
   logic [7:0]       r_word_cnt;
   logic             r_in_ready;

   logic             w_in_shift;
   logic             w_last;
   logic             w_out_bit;
   logic [WIDTH-1:0] w_shifted;

   // The output end of the register depends on bit order; zeros enter from the far end.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_out_bit = r_sreg[WIDTH-1];
         assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign w_out_bit = r_sreg[0];
         assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
      end
   endgenerate

   assign w_in_shift = (r_state == SHIFT);
   assign w_last     = w_in_shift && (r_bit_cnt == LAST_IDX);

   assign in_ready = r_in_ready;
   assign s_valid  = w_in_shift;
   assign s_data   = w_out_bit;
   assign s_last   = w_last;
   assign word_cnt = r_word_cnt;

   // in_ready is its own register so it stays low while reset is held and rises on the first edge after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_sreg     <= '0;
         r_bit_cnt  <= '0;
         r_word_cnt <= 8'd0;
         r_in_ready <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (r_in_ready && in_valid) begin
                  r_sreg     <= din;
                  r_bit_cnt  <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (s_ready) begin
                  if (w_last) begin
                     r_sreg     <= '0;
                     r_bit_cnt  <= '0;
                     r_word_cnt <= r_word_cnt + 8'd1;
                     r_in_ready <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_sreg    <= w_shifted;
                     r_bit_cnt <= r_bit_cnt + CW'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an MSB-first and an LSB-first instance share one stimulus stream.
module tb_piso_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] din;
   logic        s_ready;

   logic        in_ready_m, s_valid_m, s_data_m, s_last_m;
   logic        in_ready_l, s_valid_l, s_data_l, s_last_l;
   logic [7:0]  word_cnt_m, word_cnt_l;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_acc = 0;
   logic [7:0]  exp_cnt = 8'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   piso_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
      .in_ready(in_ready_m), .s_valid(s_valid_m), .s_data(s_data_m),
      .s_last(s_last_m), .s_ready(s_ready), .word_cnt(word_cnt_m)
   );

   piso_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
      .in_ready(in_ready_l), .s_valid(s_valid_l), .s_data(s_data_l),
      .s_last(s_last_l), .s_ready(s_ready), .word_cnt(word_cnt_l)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready_m"}, 64'(in_ready_m), 64'd1);
      chk({tag, "_in_ready_l"}, 64'(in_ready_l), 64'd1);
      chk({tag, "_s_valid_m"}, 64'(s_valid_m), 64'd0);
      chk({tag, "_s_valid_l"}, 64'(s_valid_l), 64'd0);
      chk({tag, "_s_data"}, 64'({s_data_m, s_data_l}), 64'd0);
      chk({tag, "_s_last"}, 64'({s_last_m, s_last_l}), 64'd0);
   endtask

   // Offer w, stream all 32 bits (optional stall before bit 3 transfers), check result.
   task automatic send_word(input logic [31:0] w, input int stall_len,
                            input bit hold, input logic [31:0] nxt);
      int          busy;
      int          acc;
      logic [31:0] rec_m;
      logic [31:0] rec_l;
      busy  = 0;
      rec_m = '0;
      rec_l = '0;
      in_valid = 1'b1;
      din      = w;
      step();
      acc = cyc;
      last_acc = acc;
      chk("accept_s_valid", 64'({s_valid_m, s_valid_l}), 64'd3);
      if (hold) din = nxt;
      else begin
         in_valid = 1'b0;
         din      = $urandom;
      end
      for (int i = 0; i < 32; i++) begin
         if (!in_ready_m) busy++;
         chk("bit_m", 64'(s_data_m), 64'(w[31-i]));
         chk("bit_l", 64'(s_data_l), 64'(w[i]));
         chk("last_m", 64'(s_last_m), 64'(i == 31));
         chk("last_l", 64'(s_last_l), 64'(i == 31));
         rec_m = {rec_m[30:0], s_data_m};
         rec_l[i] = s_data_l;
         if (i == 3 && stall_len > 0) begin
            s_ready = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               step();
               if (!in_ready_m) busy++;
               chk("stall_bit_m", 64'(s_data_m), 64'(w[28]));
               chk("stall_bit_l", 64'(s_data_l), 64'(w[3]));
               chk("stall_last", 64'({s_last_m, s_last_l}), 64'd0);
               chk("stall_valid", 64'({s_valid_m, s_valid_l}), 64'd3);
            end
            s_ready = 1'b1;
         end
         step();
      end
      exp_cnt = exp_cnt + 8'd1;
      chk_idle("done");
      chk("word_cnt_m", 64'(word_cnt_m), 64'(exp_cnt));
      chk("word_cnt_l", 64'(word_cnt_l), 64'(exp_cnt));
      chk("busy_cycles", 64'(busy), 64'(32 + stall_len));
      chk("word_duration", 64'(cyc - acc), 64'(32 + stall_len));
      chk("recon_m", 64'(rec_m), 64'(w));
      chk("recon_l", 64'(rec_l), 64'(w));
   endtask

   initial begin
      int a1;
      rst      = 1'b1;
      in_valid = 1'b0;
      din      = '0;
      s_ready  = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'({in_ready_m, in_ready_l}), 64'd0);
      chk("rst_s_valid", 64'({s_valid_m, s_valid_l}), 64'd0);
      chk("rst_s_data", 64'({s_data_m, s_data_l}), 64'd0);
      chk("rst_s_last", 64'({s_last_m, s_last_l}), 64'd0);
      chk("rst_word_cnt", 64'({word_cnt_m, word_cnt_l}), 64'd0);
      in_valid = 1'b1;
      din      = 32'hDEADBEEF;
      step();
      step();
      chk("rst_held_in_ready", 64'({in_ready_m, in_ready_l}), 64'd0);
      chk("rst_held_s_valid", 64'({s_valid_m, s_valid_l}), 64'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      chk_idle("release");

      // Basic MSB-first pattern; word_cnt goes 0 -> 1.
      chk("pre_word_cnt", 64'(word_cnt_m), 64'd0);
      send_word(32'hA5000001, 0, 1'b0, 32'h0);
      step();
      chk_idle("gap");

      // LSB-first pattern.
      send_word(32'h00000003, 0, 1'b0, 32'h0);

      // Backpressure: five stalled cycles before bit 3 transfers.
      send_word(32'h96C3_5A0F, 5, 1'b0, 32'h0);

      // Back-to-back with in_valid held; second word must not be taken on the last-bit edge.
      send_word(32'hFFFFFFFF, 0, 1'b1, 32'h00000000);
      a1 = last_acc;
      send_word(32'h00000000, 0, 1'b0, 32'h0);
      chk("b2b_period", 64'(last_acc - a1), 64'd33);
      chk("b2b_word_cnt", 64'(word_cnt_m), 64'd5);

      // Reset in the middle of a word.
      in_valid = 1'b1;
      din      = 32'h12345678;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      chk("mid_s_valid", 64'({s_valid_m, s_valid_l}), 64'd3);
      #3 rst = 1'b0;
      #1;
      chk("async_s_valid", 64'({s_valid_m, s_valid_l}), 64'd0);
      chk("async_in_ready", 64'({in_ready_m, in_ready_l}), 64'd0);
      chk("async_word_cnt", 64'({word_cnt_m, word_cnt_l}), 64'd0);
      chk("async_s_data", 64'({s_data_m, s_data_l}), 64'd0);
      exp_cnt = 8'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      step();
      chk_idle("post_rst");
      chk("post_rst_word_cnt", 64'(word_cnt_m), 64'd0);
      send_word(32'h80000001, 0, 1'b0, 32'h0);

      // word_cnt wrap: 255 completed words, then one more reads 0.
      for (int n = 0; n < 254; n++) send_word($urandom, 0, 1'b0, 32'h0);
      chk("wrap_255_m", 64'(word_cnt_m), 64'd255);
      chk("wrap_255_l", 64'(word_cnt_l), 64'd255);
      send_word($urandom, 0, 1'b0, 32'h0);
      chk("wrap_0_m", 64'(word_cnt_m), 64'd0);
      chk("wrap_0_l", 64'(word_cnt_l), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 32, is the parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 first.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  is the asynchronous, active-low reset.
REQ-005 in_valid  input  1  asserts that a parallel word on din is offered.
REQ-006 din  input  WIDTH  is the parallel word, produced by the upstream parallel register stage.
REQ-007 in_ready  output  1  asserts that the block accepts a word this cycle.
REQ-008 s_valid  output  1  asserts that s_data carries a valid serial bit.
REQ-009 s_data  output  1  is the current serial bit.
REQ-010 s_last  output  1  marks the final bit of a word.
REQ-011 s_ready  input  1  is downstream backpressure; a bit transfers when s_valid and s_ready are both high.
REQ-012 word_cnt  output  8  counts completed words.

Function
REQ-013 The FSM SHALL have two states, IDLE and SHIFT.
REQ-014 In IDLE, in_ready SHALL be 1, s_valid 0, s_data 0 and s_last 0.
REQ-015 In IDLE, when in_valid=1, the block SHALL on the next edge capture din into the shift register, clear bit_cnt to 0 and enter SHIFT.
REQ-016 In SHIFT, in_ready SHALL be 0, and in_valid and din SHALL be ignored.
REQ-017 In SHIFT, s_valid SHALL be 1; s_data SHALL be sreg[WIDTH-1] if MSB_FIRST=1, else sreg[0].
REQ-018 bit_cnt SHALL be $clog2(WIDTH) bits wide, and s_last SHALL equal (bit_cnt == WIDTH-1) while in SHIFT.
REQ-019 On a transfer with s_last=0, the block SHALL shift the register one position toward the output end, zero-fill the vacated bit, and increment bit_cnt.
REQ-020 On a transfer with s_last=1, the block SHALL return to IDLE, clear the shift register, and increment word_cnt modulo 256 (255 -> 0).
REQ-021 While s_ready=0 in SHIFT, sreg, bit_cnt, s_data and s_last SHALL hold unchanged.
REQ-022 Latency: the first bit SHALL appear on s_data the cycle after the accept edge.
REQ-023 Throughput with s_ready held at 1: one word every WIDTH+1 cycles, consisting of the accept cycle plus WIDTH bit cycles.
REQ-024 No combinational path SHALL exist from in_valid or s_ready to in_ready or s_valid; both are decoded from state only.
REQ-025 The transfer of the last bit and a new offer on in_valid in the same cycle SHALL NOT cause an accept; the new word is accepted in the following IDLE cycle.

Reset
REQ-026 When rst=0, the block SHALL immediately, without waiting for a clock edge, enter IDLE and clear sreg, bit_cnt and word_cnt to 0.
REQ-027 During reset, outputs SHALL be in_ready=0, s_valid=0, s_data=0, s_last=0, word_cnt=0.
REQ-028 On the first edge after rst returns to 1, in_ready SHALL be 1.
REQ-029 A reset asserted mid-word SHALL discard the word, and word_cnt SHALL NOT increment.

Verification
REQ-030 Basic MSB-first: WIDTH=32, MSB_FIRST=1, din=32'hA5000001, s_ready=1 -> s_data sequence 1,0,1,0,0,1,0,1, then 23 zeros, then 1; s_last=1 only on bit 32; word_cnt 0 -> 1.
REQ-031 LSB-first: MSB_FIRST=0, din=32'h00000003 -> s_data sequence 1,1, then 30 zeros; in_ready is 0 for exactly 32 cycles.
REQ-032 Backpressure: s_ready=0 for 5 cycles after bit 3 -> s_data and s_last frozen for those 5 cycles, no bit lost or duplicated, the full 32-bit word is reconstructed, and the word completes 5 cycles late.
REQ-033 Back-to-back: in_valid held at 1 with words 32'hFFFFFFFF then 32'h00000000 -> the second word is accepted one cycle after the first word's s_last transfer; 33 cycles per word; word_cnt=2.
REQ-034 Reset mid-word: rst=0 asynchronously after bit 10 -> s_valid drops immediately; after release in_ready=1, word_cnt=0, and the next word is serialized from its bit 31.
REQ-035 Wrap: 256 completed words -> word_cnt reads 255, then 0.
